// File: rtl/seq_det_pkg.sv
// Shared defaults for the serial pattern detector family.
// Holds the default pattern length, pattern, overlap mode and counter width.
// Also provides the helper that sizes the fill counter. The fill counter
// must be able to hold 0..W inclusive.
package seq_det_pkg;

  localparam int              DEF_W       = 4;
  localparam logic [DEF_W-1:0] DEF_PATTERN = 4'b1010;
  localparam bit              DEF_OVERLAP = 1'b1;
  localparam int              DEF_CNT_W   = 8;

  // Number of bits needed to count from 0 up to and including w
  function automatic int fill_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used as the detector's match counter.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears count
//   clr    synchronous clear, takes priority over inc
//   inc    increment request; ignored once count is all ones
//   count  current value, holds at 2^CNT_W-1 instead of wrapping
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count up on inc, stick at the top value, and clear on request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector with a run-time loadable pattern.
// It samples one bit per clock while in_valid is high. It pulses out for
// one cycle when the last W sampled bits equal pattern_q, with the MSB being
// the oldest bit.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   in_valid     qualifies in
//   in           serial data bit
//   cfg_load     load cfg_pattern / cfg_overlap and restart detection
//   cfg_pattern  new pattern (MSB oldest)
//   cfg_overlap  new overlap mode (1 = matches may share bits)
//   out          registered one-cycle match pulse
//   match_count  saturating match count since reset or cfg_load
//   pattern_q    active pattern readback
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int             W       = DEF_W,
  parameter logic [W-1:0]   PATTERN = W'(DEF_PATTERN),
  parameter bit             OVERLAP = DEF_OVERLAP,
  parameter int             CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [W-1:0]     cfg_pattern,
  input  logic             cfg_overlap,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic [W-1:0]     pattern_q
);

  localparam int             FW       = fill_width(W);
  localparam logic [FW-1:0]  FILL_MAX = FW'(W);
  localparam logic [FW-1:0]  FILL_PRE = FW'(W - 1);

  logic [W-1:0]  hist;
  logic [FW-1:0] fill;
  logic          overlap_q;
  logic [W-1:0]  nxt;
  logic          hit;

  // Candidate history including the bit on the wire this cycle.
  // The fill guard stops the zero-initialised history from matching an
  // all-zero pattern before W real bits have arrived.
  always_comb begin
    nxt = {hist[W-2:0], in};
    hit = in_valid && !cfg_load && (fill >= FILL_PRE) && (nxt == pattern_q);
  end

  // Configuration, history and the registered match pulse.
  // A config load restarts detection from an empty history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= PATTERN;
      overlap_q <= OVERLAP;
      hist      <= '0;
      fill      <= '0;
      out       <= 1'b0;
    end else if (cfg_load) begin
      pattern_q <= cfg_pattern;
      overlap_q <= cfg_overlap;
      hist      <= '0;
      fill      <= '0;
      out       <= 1'b0;
    end else if (in_valid) begin
      out <= hit;
      if (hit && !overlap_q) begin
        hist <= '0;
        fill <= '0;
      end else if (hit) begin
        hist <= nxt;
        fill <= FILL_MAX;
      end else begin
        hist <= nxt;
        fill <= (fill == FILL_MAX) ? FILL_MAX : fill + 1'b1;
      end
    end else begin
      out <= 1'b0;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cfg_load),
    .inc  (hit),
    .count(match_count)
  );

endmodule

// File: tb/tb_seq_detector.sv
// Testbench for seq_detector.
// It drives two instances with the same stimulus: the default one with an
// 8-bit counter, and one with a 2-bit counter to exercise saturation.
// A queue-based model of the matching rules predicts every output.
module tb_seq_detector;
  import seq_det_pkg::*;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in = 1'b0;
  logic       cfg_load = 1'b0;
  logic [W-1:0] cfg_pattern = '0;
  logic       cfg_overlap = 1'b0;

  logic       out_a, out_b;
  logic [7:0] count_a;
  logic [1:0] count_b;
  logic [W-1:0] pat_a, pat_b;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Behavioural model state
  bit           hq[$];
  int           m_cnt;
  bit           m_out;
  logic [W-1:0] m_pat;
  bit           m_ovl;
  logic [W-1:0] m_last;
  bit           m_hit;

  seq_detector u_dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .out(out_a), .match_count(count_a), .pattern_q(pat_a)
  );

  seq_detector #(.CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .out(out_b), .match_count(count_b), .pattern_q(pat_b)
  );

  always #5 clk = ~clk;

  // Reference model: keep the most recent sampled bits since the last restart.
  // A match is declared when at least W of them exist and the newest W read as
  // the pattern. A non-overlapping match forgets everything it has seen.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hq.delete();
      m_cnt = 0;
      m_out = 0;
      m_pat = DEF_PATTERN;
      m_ovl = DEF_OVERLAP;
    end else if (cfg_load) begin
      hq.delete();
      m_cnt = 0;
      m_out = 0;
      m_pat = cfg_pattern;
      m_ovl = cfg_overlap;
    end else if (in_valid) begin
      hq.push_back(in);
      if (hq.size() > W) void'(hq.pop_front());
      m_hit = 0;
      if (hq.size() == W) begin
        for (int i = 0; i < W; i++) m_last[i] = hq[W-1-i];
        m_hit = (m_last == m_pat);
      end
      m_out = m_hit;
      if (m_hit) begin
        m_cnt++;
        if (!m_ovl) hq.delete();
      end
    end else begin
      m_out = 0;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge compares both instances against the model
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      checkOutput("out_a", out_a, m_out);
      checkOutput("out_b", out_b, m_out);
      checkOutput("count_a", count_a, (m_cnt > 255) ? 255 : m_cnt);
      checkOutput("count_b", count_b, (m_cnt > 3) ? 3 : m_cnt);
      checkOutput("pattern_a", pat_a, m_pat);
      checkOutput("pattern_b", pat_b, m_pat);
    end
  end

  // Drive one cycle of inputs after the falling edge and return just after the rising edge
  task automatic applyStimulus(input logic v, input logic b, input logic l,
                               input logic [W-1:0] p, input logic o);
    @(negedge clk);
    #1;
    in_valid    = v;
    in          = b;
    cfg_load    = l;
    cfg_pattern = p;
    cfg_overlap = o;
    @(posedge clk);
    #1;
  endtask

  // Feed n valid bits (MSB first) and pin each resulting pulse to a literal
  task automatic runBits(input string tag, input int n, input logic [15:0] bits,
                         input logic [15:0] exp_out);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(1'b1, bits[i], 1'b0, '0, 1'b0);
      checkOutput({tag, "_out"}, out_a, exp_out[i]);
      checkOutput({tag, "_model"}, m_out, exp_out[i]);
    end
  endtask

  // Asynchronous reset pulse in the middle of a cycle; outputs must clear at once
  task automatic pulseReset();
    #1 reset = 1'b1;
    #1;
    checkOutput("async_rst_out", out_a, 0);
    checkOutput("async_rst_cnt", count_a, 0);
    checkOutput("async_rst_pat", pat_a, 4'b1010);
    #1 reset = 1'b0;
  endtask

  int r;

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1;
    checkOutput("reset_out", out_a, 0);
    checkOutput("reset_cnt", count_a, 0);
    checkOutput("reset_pat", pat_a, 4'b1010);

    // Default 1010 overlapping: pulses after bits 4 and 6
    runBits("t1", 6, 16'b101010, 16'b000101);
    checkOutput("t1_cnt", count_a, 2);

    // Non-overlapping: the 6th bit cannot reuse the first match
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b1010, 1'b0);
    checkOutput("t2_load_cnt", count_a, 0);
    runBits("t2", 8, 16'b10101010, 16'b00010001);
    checkOutput("t2_cnt", count_a, 2);

    // All-zero pattern: fill guard suppresses early matches
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 1'b1);
    runBits("t3", 6, 16'b000000, 16'b000111);
    checkOutput("t3_cnt", count_a, 3);

    // Idle gap inside a pattern neither breaks it nor stretches the pulse
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b1010, 1'b1);
    runBits("t4a", 2, 16'b10, 16'b00);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("t4_gap_out", out_a, 0);
    end
    runBits("t4b", 2, 16'b10, 16'b01);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("t4_idle_out", out_a, 0);
    checkOutput("t4_cnt", count_a, 1);

    // Saturation: 8 ones against 1111 give 5 matches, 2-bit counter stops at 3
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1);
    runBits("t5", 8, 16'b11111111, 16'b00011111);
    checkOutput("t5_cnt_a", count_a, 5);
    checkOutput("t5_cnt_b", count_b, 3);

    // Reset while a pulse is showing, then mid-prefix reset loses the prefix
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b1010, 1'b1);
    runBits("t6a", 4, 16'b1010, 16'b0001);
    pulseReset();
    runBits("t6b", 3, 16'b101, 16'b000);
    pulseReset();
    runBits("t6c", 1, 16'b0, 16'b0);
    runBits("t6d", 4, 16'b1010, 16'b0001);
    checkOutput("t6_cnt", count_a, 1);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 999);
      if (r < 5) begin
        pulseReset();
      end else if (r < 25) begin
        applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), 1'b1,
                      W'($urandom_range(0, 15)), $urandom_range(0, 1));
      end else begin
        applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 1), 1'b0,
                      W'($urandom_range(0, 15)), $urandom_range(0, 1));
      end
    end

    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
Name: seq_detector

Overview:
Parametrised serial pattern detector: samples one bit per qualified clock and pulses an output when the last W sampled bits equal a run-time loadable pattern. Supports overlapping and non-overlapping detection and keeps a saturating match counter. Intended for serial-stream lab datapaths; drops in where the fixed 4-bit "1010" detector sits, with identical timing in default configuration.

Parameters:
W, 4, pattern length in bits (W >= 2)
PATTERN, 4'b1010, reset value of the pattern register (W bits; MSB = oldest bit)
OVERLAP, 1, reset value of the overlap-mode register (1 = overlapping)
CNT_W, 8, width of match_count

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  qualifies in; bit sampled only when 1
in  input  1  serial data bit
cfg_load  input  1  load cfg_pattern/cfg_overlap this edge
cfg_pattern  input  W  new pattern (MSB oldest)
cfg_overlap  input  1  new overlap mode
out  output  1  registered one-cycle match pulse
match_count  output  CNT_W  saturating number of matches since reset/cfg_load
pattern_q  output  W  currently active pattern (status readback)

Behaviour:
- One clock (clk); reset asynchronous, active-high. Reset: out=0, match_count=0, history=0, fill=0, pattern_q=PATTERN, overlap=OVERLAP.
- State: history shift register hist[W-1:0], fill counter fill (0..W, width $clog2(W+1), saturates at W), pattern_q, overlap_q.
- Priority per edge: reset > cfg_load > in_valid > idle.
- cfg_load=1: pattern_q<=cfg_pattern, overlap_q<=cfg_overlap, hist<=0, fill<=0, match_count<=0, out<=0; in/in_valid ignored that edge.
- in_valid=1 (no cfg_load): nxt={hist[W-2:0],in}; hit = (fill >= W-1) && (nxt == pattern_q).
  - out<=hit (high for exactly the cycle following the edge sampling the completing bit; latency 1 edge, identical to legacy detector).
  - hit && overlap_q: hist<=nxt, fill<=W (history retained; suffixes reused).
  - hit && !overlap_q: hist<=0, fill<=0 (next match needs W fresh bits).
  - no hit: hist<=nxt, fill<=min(fill+1,W).
  - hit: match_count<=match_count+1, holding at 2^CNT_W-1 (no wrap).
- in_valid=0: hist, fill, match_count hold; out<=0 (pulse never stretched across idle cycles).
- Zero-fill history never causes a false match: fill guard required even if pattern is all zeros.
- Pattern change via cfg_load only; pattern_q never changes mid-stream otherwise.
- Reset asserted mid-pattern: all state cleared immediately (asynchronously); partial prefix lost.
- No combinational path from inputs to any output.

Decomposition:
- Shared package seq_det_pkg: default constants (DEF_W=4, DEF_PATTERN, DEF_CNT_W=8) and fill-width function; no typedefs needed.
- One sub-module natural: sat_counter (parameter CNT_W; ports clk, reset, clr, inc, count) for match_count. Shift/compare logic stays in seq_detector.

Test Plan:
- Defaults, in_valid=1, in=1,0,1,0,1,0 -> out high the cycle after 4th and 6th bits only; match_count=2.
- cfg_load cfg_pattern=4'b1010 cfg_overlap=0, then same 6 bits -> single pulse after 4th bit; further 1,0 -> pulse after 8th; match_count=2.
- Pattern 4'b0000, overlap=1, 4 zeros after cfg_load -> no pulse before 4th bit, pulses after bits 4,5,6 for six zeros; count=3.
- in=1,0,(in_valid=0 x3),1,0 with 1010 -> one pulse after final bit; out low during gap; count=1.
- CNT_W=2, pattern 4'b1111 overlap=1, 8 ones -> 5 pulses, match_count stops at 3.
- Reset pulse mid-sequence after 1,0,1, then 0 -> no pulse; outputs 0 immediately on reset; subsequent 1,0,1,0 -> pulse, count=1.
